// File: rtl/adc_uart_tx.sv
// Serialises one captured ADC word onto an 8N1 UART line as two bytes:
// the zero-extended upper bits first, then the low eight bits.
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | start bit (0) of the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); chains to byte 1 or finishes the frame
module adc_uart_tx #(
   parameter int Width   = 12,
   parameter int BaudDiv = 434
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Width-1:0] din_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             tx_o
);

   localparam int BW = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BaudDiv - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [Width-1:0] hold_q, hold_d;
   logic [BW-1:0]    baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             byte_sel_q, byte_sel_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [7:0] byte_hi;
   logic [7:0] cur_byte;
   logic [2:0] nxt_idx;
   logic       bit_end;

   assign byte_hi  = 8'(hold_q[Width-1:8]);
   assign cur_byte = byte_sel_q ? hold_q[7:0] : byte_hi;
   assign nxt_idx  = bit_idx_q + 3'd1;
   assign bit_end  = (baud_q == BAUD_LAST);

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      byte_sel_d = byte_sel_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start_i) begin
               hold_d     = din_i;
               busy_d     = 1'b1;
               tx_d       = 1'b0;
               state_d    = START;
               byte_sel_d = 1'b0;
               baud_d     = '0;
               bit_idx_d  = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
               tx_d      = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = nxt_idx;
                  tx_d      = cur_byte[nxt_idx];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_sel_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         byte_sel_q <= byte_sel_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Directed bench for adc_uart_tx with BaudDiv=4, Width=12; each task
// drives one scenario and checks tx/busy/done cycle by cycle.
module tb_adc_uart_tx;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [11:0] din_i = 12'h000;
   logic        busy_o;
   logic        done_o;
   logic        tx_o;

   int n_tests = 0;
   int n_fail  = 0;

   adc_uart_tx #(.Width(12), .BaudDiv(4)) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(start_i),
      .din_i  (din_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .tx_o   (tx_o)
   );

   always #5 clk_i = ~clk_i;

   // Call at a negedge: request a frame and return just after accepting edge k.
   task automatic do_start(input logic [11:0] word);
      din_i   = word;
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
   endtask

   // Entered just after edge k; returns at the negedge following edge k+80.
   task automatic check_frame(input string name, input logic [7:0] b0,
                              input logic [7:0] b1, input bit disturb);
      logic [19:0] bits;
      bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
      for (int c = 0; c < 80; c++) begin
         @(negedge clk_i);
         n_tests++;
         if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy/done c=%0d: got busy=%b done=%b, want 1/0",
                     name, c, busy_o, done_o);
         end
         if (c % 4 == 2) begin
            n_tests++;
            if (tx_o !== bits[c/4]) begin
               n_fail++;
               $display("FAIL %s tx bit%0d: got %b, want %b", name, c/4, tx_o, bits[c/4]);
            end
         end
         if (disturb) begin
            if (c == 9) begin
               start_i = 1'b1;
               din_i   = 12'h123;
            end else begin
               start_i = 1'b0;
               din_i   = ~din_i;
            end
         end
      end
      @(negedge clk_i);
      n_tests++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s end: got done=%b busy=%b tx=%b, want 1/0/1",
                  name, done_o, busy_o, tx_o);
      end
   endtask

   task automatic check_idle(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk_i);
         n_tests++;
         if (busy_o !== 1'b0 || done_o !== 1'b0 || tx_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle c=%0d: got busy=%b done=%b tx=%b, want 0/0/1",
                     name, c, busy_o, done_o, tx_o);
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_i = 1'b1;
      #1;
      n_tests++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got tx=%b busy=%b done=%b, want 1/0/0",
                  tx_o, busy_o, done_o);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check_idle("reset_release", 4);
   endtask

   task automatic test_basic();
      do_start(12'hA5C);
      check_frame("a5c", 8'h0A, 8'h5C, 1'b0);
      check_idle("a5c_after", 3);
   endtask

   task automatic test_extremes();
      do_start(12'hFFF);
      check_frame("fff", 8'h0F, 8'hFF, 1'b0);
      @(negedge clk_i);
      do_start(12'h000);
      check_frame("000", 8'h00, 8'h00, 1'b0);
      check_idle("000_after", 2);
   endtask

   task automatic test_ignore_busy();
      do_start(12'hA5C);
      check_frame("ignore", 8'h0A, 8'h5C, 1'b1);
      din_i = 12'h000;
      check_idle("ignore_after", 12);
   endtask

   task automatic test_back_to_back();
      @(negedge clk_i);
      do_start(12'hA5C);
      check_frame("b2b_first", 8'h0A, 8'h5C, 1'b0);
      do_start(12'h3C1);
      check_frame("b2b_second", 8'h03, 8'hC1, 1'b0);
      check_idle("b2b_after", 2);
   endtask

   task automatic test_mid_reset();
      @(negedge clk_i);
      do_start(12'hA5C);
      repeat (29) @(negedge clk_i);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      n_tests++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got tx=%b busy=%b done=%b, want 1/0/0",
                  tx_o, busy_o, done_o);
      end
      // start_i high during reset must not be latched
      start_i = 1'b1;
      din_i   = 12'hFFF;
      @(negedge clk_i);
      start_i = 1'b0;
      rst_i   = 1'b0;
      check_idle("mid_reset_after", 60);
      do_start(12'h7E4);
      check_frame("7e4", 8'h07, 8'hE4, 1'b0);
      check_idle("7e4_after", 2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_ignore_busy();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
